// File: rtl/call_ret_ctrl_pkg.sv
// call_ret_ctrl_pkg
// Shared definitions for the CALL/RET controller slice:
//   - stack opcodes (bit 3 marks an active stack operation; the stack acts on
//     the rising edge of that bit, so a NOP must separate consecutive ops)
//   - FSM state encodings for call_ret_ctrl
package call_ret_ctrl_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_PUSH_R = 4'h9;
    localparam logic [3:0] OP_POP_R  = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_POP  = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/call_ret_depth.sv
// call_ret_depth
// Stack depth tracker for the optional overflow/underflow guard.
// Counts 0..DEPTH; the parent only pulses i_inc when not full and i_dec when
// not empty, so the counter itself needs no saturation.
// Ports:
//   clk, reset       clock, synchronous active-high reset (depth -> 0)
//   i_inc / i_dec    one-cycle increment / decrement requests
//   o_full           depth == DEPTH
//   o_empty          depth == 0
module call_ret_depth #(
    parameter int DEPTH = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] r_depth;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
        end else if (i_inc) begin
            r_depth <= r_depth + 1'b1;
        end else if (i_dec) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign o_full  = (r_depth == CNT_W'(DEPTH));
    assign o_empty = (r_depth == '0);

endmodule

// File: rtl/call_ret_ctrl.sv
// call_ret_ctrl
// Sequences CALL (push return address) and RET (pop return address) requests
// onto an external registered stack and returns one response per request.
// Sequence: IDLE -> PUSH|POP -> CAPT -> RESP -> IDLE (4 cycles per request
// with rsp_ready held high).
// Optional feature macro: CALL_RET_GUARD_EN -- adds a depth tracker that
// suppresses pushes when full / pops when empty and flags rsp_err.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_call, req_addr         1 = CALL with return address, 0 = RET
//   stk_opcode, stk_push       opcode and push data to the stack
//   stk_pop                    registered pop data from the stack
//   rsp_valid/rsp_ready        response handshake
//   rsp_addr, rsp_err          saved/popped address, overflow/underflow flag
module call_ret_ctrl
    import call_ret_ctrl_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_call,
    input  logic [DATA_W-1:0] req_addr,
    output logic [3:0]        stk_opcode,
    output logic [DATA_W-1:0] stk_push,
    input  logic [DATA_W-1:0] stk_pop,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_addr,
    output logic              rsp_err
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_call;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] w_capt_addr;
    logic              w_accept;
    logic              w_skip;

    assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef CALL_RET_GUARD_EN
    logic w_full;
    logic w_empty;
    logic w_inc;
    logic w_dec;
    logic r_skip;
    logic r_rsp_err;

    // A guarded operation is replaced by a NOP; the depth only moves when
    // the real opcode goes out.
    assign w_skip = ((r_state == ST_PUSH) && w_full) ||
                    ((r_state == ST_POP)  && w_empty);
    assign w_inc  = (r_state == ST_PUSH) && !w_full;
    assign w_dec  = (r_state == ST_POP)  && !w_empty;

    call_ret_depth #(
        .DEPTH (DEPTH)
    ) u_depth (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip    <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if ((r_state == ST_PUSH) || (r_state == ST_POP)) begin
                r_skip <= w_skip;
            end
            if (r_state == ST_CAPT) begin
                r_rsp_err <= r_skip;
            end
        end
    end

    assign rsp_err     = r_rsp_err;
    // Underflowed RET reports address 0 rather than stale stack data.
    assign w_capt_addr = r_call ? r_addr : (r_skip ? '0 : stk_pop);
`else
    assign w_skip      = 1'b0;
    assign rsp_err     = 1'b0;
    assign w_capt_addr = r_call ? r_addr : stk_pop;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = req_call ? ST_PUSH : ST_POP;
                end
            end
            ST_PUSH: w_next_state = ST_CAPT;
            ST_POP:  w_next_state = ST_CAPT;
            ST_CAPT: w_next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        stk_opcode = OP_NOP;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_PUSH: begin
                if (!w_skip) begin
                    stk_opcode = OP_PUSH_R;
                end
            end
            ST_POP: begin
                if (!w_skip) begin
                    stk_opcode = OP_POP_R;
                end
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
        // An in-flight op is dropped the moment reset is seen.
        if (reset) begin
            stk_opcode = OP_NOP;
        end
    end

    // Request latch and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_call     <= 1'b0;
            r_addr     <= '0;
            r_rsp_addr <= '0;
        end else begin
            if (w_accept) begin
                r_call <= req_call;
                if (req_call) begin
                    r_addr <= req_addr;
                end
            end
            // stk_pop is valid in CAPT, one cycle after the POP opcode.
            if (r_state == ST_CAPT) begin
                r_rsp_addr <= w_capt_addr;
            end
        end
    end

    assign stk_push = r_addr;
    assign rsp_addr = r_rsp_addr;

endmodule

// File: tb/tb_call_ret_ctrl.sv
module tb_call_ret_ctrl;
    import call_ret_ctrl_pkg::*;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 12;
`ifdef CALL_RET_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_call = 1'b0;
    logic [DATA_W-1:0] req_addr = '0;
    logic [3:0]        stk_opcode;
    logic [DATA_W-1:0] stk_push;
    logic [DATA_W-1:0] stk_pop;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_addr;
    logic              rsp_err;

    always #5 clk = ~clk;

    call_ret_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_call   (req_call),
        .req_addr   (req_addr),
        .stk_opcode (stk_opcode),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_err    (rsp_err)
    );

    // Behavioural registered stack plus opcode monitors
    logic [DATA_W-1:0] stk_q[$];
    int                n_push = 0;
    int                n_pop  = 0;
    int                n_adj  = 0;
    int                n_bad  = 0;
    logic [3:0]        prev_op = OP_NOP;

    always @(posedge clk) begin
        if (reset) begin
            stk_q.delete();
            stk_pop <= '0;
        end else if (stk_opcode == OP_PUSH_R) begin
            stk_q.push_back(stk_push);
        end else if (stk_opcode == OP_POP_R) begin
            if (stk_q.size() > 0) stk_pop <= stk_q.pop_back();
            else                  stk_pop <= '0;
        end
        if (stk_opcode == OP_PUSH_R) n_push <= n_push + 1;
        if (stk_opcode == OP_POP_R)  n_pop  <= n_pop + 1;
        if (stk_opcode != OP_NOP && stk_opcode != OP_PUSH_R && stk_opcode != OP_POP_R)
            n_bad <= n_bad + 1;
        if (stk_opcode != OP_NOP && prev_op != OP_NOP) n_adj <= n_adj + 1;
        prev_op <= stk_opcode;
    end

    // Reference model: expected return-address stack
    logic [DATA_W-1:0] ref_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ref_q.delete();
    endtask

    task automatic xact(input string tag, input logic call, input logic [DATA_W-1:0] addr,
                        input int hold, input logic early,
                        input logic [DATA_W-1:0] exp_addr, input logic exp_err,
                        input logic [3:0] exp_op, input int exp_push, input int exp_pop);
        int p0, q0, lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_call  = call;
        req_addr  = addr;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        p0 = n_push;
        q0 = n_pop;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_call  = 1'($urandom);
        req_addr  = DATA_W'($urandom);
        rsp_ready = early;
        chk({tag, ".op"}, 32'(stk_opcode), 32'(exp_op));
        if (exp_op == OP_PUSH_R) chk({tag, ".stk_push"}, 32'(stk_push), 32'(addr));
        chk({tag, ".vld1"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".op_nop"}, 32'(stk_opcode), 32'(OP_NOP));
        lat = 2;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        chk({tag, ".rsp_addr"}, 32'(rsp_addr), 32'(exp_addr));
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".busy"}, 32'(req_ready), 32'd0);
        if (hold > 0) begin
            req_valid = 1'b1;
            req_call  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_vld"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_addr"}, 32'(rsp_addr), 32'(exp_addr));
            chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
            chk({tag, ".hold_op"}, 32'(stk_opcode), 32'(OP_NOP));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".done"}, 32'(req_ready), 32'd1);
        chk({tag, ".n_push"}, 32'(n_push - p0), 32'(exp_push));
        chk({tag, ".n_pop"}, 32'(n_pop - q0), 32'(exp_pop));
    endtask

    task automatic model_xact(input string tag, input logic call, input logic [DATA_W-1:0] addr,
                              input int hold, input logic early);
        logic [DATA_W-1:0] ea;
        logic              ee;
        logic [3:0]        eop;
        int                ep, eq;
        ea = '0; ee = 1'b0; eop = OP_NOP; ep = 0; eq = 0;
        if (call) begin
            ea = addr;
            if (GUARD && ref_q.size() >= DEPTH) begin
                ee = 1'b1;
            end else begin
                ref_q.push_back(addr);
                eop = OP_PUSH_R;
                ep  = 1;
            end
        end else begin
            if (ref_q.size() == 0) begin
                ee  = GUARD;
                eop = GUARD ? OP_NOP : OP_POP_R;
                eq  = GUARD ? 0 : 1;
            end else begin
                ea  = ref_q.pop_back();
                eop = OP_POP_R;
                eq  = 1;
            end
        end
        xact(tag, call, addr, hold, early, ea, ee, eop, ep, eq);
    endtask

    initial begin
        int p0;
        logic call;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.op", 32'(stk_opcode), 32'(OP_NOP));
        chk("rst.stk_push", 32'(stk_push), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        chk("rst.req_ready", 32'(req_ready), 32'd1);

        // Single CALL
        model_xact("call123", 1'b1, 14'h0123, 0, 1'b0);

        // Nested CALL/RET against the stack
        do_reset();
        model_xact("callA", 1'b1, 14'h000A, 0, 1'b0);
        model_xact("callB", 1'b1, 14'h000B, 0, 1'b0);
        model_xact("retB",  1'b0, 14'h3FFF, 0, 1'b0);
        model_xact("retA",  1'b0, 14'h3FFF, 0, 1'b0);

        // Backpressure in RESP, with a stray req_valid
        model_xact("hold5", 1'b1, 14'h1234, 5, 1'b0);
        model_xact("hold5r", 1'b0, 14'h0, 5, 1'b0);

        // rsp_ready high before RESP
        model_xact("early", 1'b1, 14'h2222, 0, 1'b1);
        model_xact("earlyr", 1'b0, 14'h0, 0, 1'b1);

        // Reset during PUSH
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_call  = 1'b1;
        req_addr  = 14'h0155;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstpush.op_before", 32'(stk_opcode), 32'(OP_PUSH_R));
        reset = 1'b1;
        p0 = n_push;
        @(posedge clk);
        #1;
        chk("rstpush.op", 32'(stk_opcode), 32'(OP_NOP));
        chk("rstpush.vld", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        chk("rstpush.ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstpush.vld_after", 32'(rsp_valid), 32'd0);
        chk("rstpush.no_push", 32'(n_push - p0), 32'd0);
        ref_q.delete();

`ifdef CALL_RET_GUARD_EN
        // Underflow and overflow guard
        do_reset();
        model_xact("g_under", 1'b0, 14'h0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) model_xact("g_fill", 1'b1, DATA_W'($urandom), 0, 1'b0);
        model_xact("g_over", 1'b1, 14'h03AB, 0, 1'b0);
        model_xact("g_top", 1'b0, 14'h0, 0, 1'b0);
        model_xact("g_refill", 1'b1, 14'h0777, 0, 1'b0);
        model_xact("g_over2", 1'b1, 14'h0888, 1, 1'b0);
`endif

        // Randomized traffic, depth kept within 0..DEPTH
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int h;
            if (ref_q.size() == 0)          call = 1'b1;
            else if (ref_q.size() >= DEPTH) call = 1'b0;
            else                            call = 1'($urandom_range(0, 1));
            h = $urandom_range(0, 2);
            model_xact("rand", call, DATA_W'($urandom), h, (h == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        chk("adjacent_ops", 32'(n_adj), 32'd0);
        chk("illegal_ops", 32'(n_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/call_ret_ctrl.md
CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, meaning width of return addresses and stack data.
REQ-002 The block SHALL have parameter DEPTH, default 12, meaning stack entry count used by the guard.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, CALL/RET request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted when both are high.
REQ-007 The block SHALL have port req_call, input, 1: 1 = CALL (push), 0 = RET (pop).
REQ-008 The block SHALL have port req_addr, input, DATA_W, return address to save on CALL; ignored on RET.
REQ-009 The block SHALL have port stk_opcode, output, 4, opcode to the stack.
REQ-010 The block SHALL have port stk_push, output, DATA_W, data to the stack.
REQ-011 The block SHALL have port stk_pop, input, DATA_W, registered pop data from the stack.
REQ-012 The block SHALL have port rsp_valid, output, 1, response present.
REQ-013 The block SHALL have port rsp_ready, input, 1, response consumed when both are high.
REQ-014 The block SHALL have port rsp_addr, output, DATA_W: echo of saved address on CALL, popped address on RET.
REQ-015 The block SHALL have port rsp_err, output, 1, overflow/underflow flag, valid with rsp_valid.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, PUSH, POP, CAPT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance with req_call=1, req_addr SHALL be latched and IDLE->PUSH.
REQ-019 On acceptance with req_call=0, IDLE->POP.
REQ-020 PUSH SHALL drive stk_opcode=OP_PUSH_R and stk_push=latched address for exactly one cycle, then go to CAPT.
REQ-021 POP SHALL drive stk_opcode=OP_POP_R for exactly one cycle, then go to CAPT.
REQ-022 CAPT SHALL drive stk_opcode=OP_NOP (bit 3 low, re-arming the stack pointer edge); on RET it SHALL latch stk_pop into rsp_addr; then go to RESP.
REQ-023 In every state other than PUSH/POP, stk_opcode SHALL be OP_NOP.
REQ-024 RESP SHALL hold rsp_valid=1 and stable rsp_addr/rsp_err until rsp_ready=1, then go to IDLE.
REQ-025 Latency SHALL be 3 cycles from the accept edge to rsp_valid=1 for both CALL and RET; back-to-back throughput is one request per 4 cycles with rsp_ready held high.
REQ-026 rsp_ready asserted outside RESP SHALL have no effect; req_valid outside IDLE SHALL be ignored.
REQ-027 Reset asserted in any state SHALL abort the operation with no further stack opcode issued.

Reset
REQ-028 Reset SHALL set state=IDLE, stk_opcode=OP_NOP, stk_push=0, rsp_valid=0, rsp_addr=0, rsp_err=0, and guard depth=0.
REQ-029 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With macro CALL_RET_GUARD_EN defined, the block SHALL track depth 0..DEPTH: a successful CALL increments and a successful RET decrements at the PUSH/POP cycle.
REQ-031 With CALL_RET_GUARD_EN defined, a CALL at depth==DEPTH SHALL skip the PUSH opcode (NOP instead), leave depth unchanged, and respond rsp_err=1 with rsp_addr=req_addr.
REQ-032 With CALL_RET_GUARD_EN defined, a RET at depth==0 SHALL skip the POP opcode, leave depth unchanged, and respond rsp_err=1 with rsp_addr=0.
REQ-033 Without CALL_RET_GUARD_EN, the block SHALL have no depth logic, SHALL tie rsp_err to 0, and SHALL always issue opcodes.

Structure
REQ-034 OP_PUSH_R, OP_POP_R, and OP_NOP SHALL come from the shared opcode definitions; FSM state encodings SHALL be constants in that shared package.
REQ-035 The guard counter SHALL be a sub-module call_ret_depth, instantiated only under CALL_RET_GUARD_EN.

Verification
REQ-036 The bench SHALL check: CALL req_addr=0x0123 -> one cycle of OP_PUSH_R with stk_push=0x0123, then NOP, and rsp_valid 3 cycles after accept with rsp_addr=0x0123, rsp_err=0.
REQ-037 The bench SHALL check: CALL 0x0A, CALL 0x0B, RET, RET against the real stack -> rsp_addr 0x0B then 0x0A, with a NOP between every push/pop.
REQ-038 The bench SHALL check: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_addr stable, req_ready=0, no opcodes issued.
REQ-039 The bench SHALL check, with the guard: 12 CALLs then a 13th -> 13th gives rsp_err=1 and no OP_PUSH_R; RET at reset depth 0 -> rsp_err=1, rsp_addr=0.
REQ-040 The bench SHALL check: reset asserted during PUSH -> next cycle stk_opcode=OP_NOP, rsp_valid=0, req_ready=1 after release.
